// File: rtl/mouse_cursor_ctrl.sv
// PS/2 mouse packet assembler and cursor position tracker.
// The pending position is committed to the painter outputs only on frame_start.
module mouse_cursor_ctrl #(
  parameter int X_MAX   = 632,
  parameter int Y_MAX   = 469,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int TIMEOUT = 50000,
  parameter int TO_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       frame_start,
  output logic [9:0] mouse_x,
  output logic [8:0] mouse_y,
  output logic       btn_left,
  output logic       btn_right,
  output logic       packet_err
);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, APPLY} state_e;

  localparam logic signed [11:0] XM      = 12'(X_MAX);
  localparam logic signed [11:0] YM      = 12'(Y_MAX);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  // header keeps only the bits used later: {yov, xov, ysign, xsign, right, left}
  logic [5:0]        hdr_q, hdr_d;
  logic [7:0]        b1_q, b1_d, b2_q, b2_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [9:0]        pend_x_q, pend_x_d, mouse_x_q;
  logic [8:0]        pend_y_q, pend_y_d, mouse_y_q;
  logic [1:0]        btn_q, btn_d;
  logic              err_q, err_d;
  logic signed [11:0] dx, dy, nx, ny;

  assign dx = {{3{hdr_q[2]}}, hdr_q[2], b1_q};
  assign dy = {{3{hdr_q[3]}}, hdr_q[3], b2_q};
  assign nx = $signed({2'b00, pend_x_q}) + dx;
  assign ny = $signed({3'b000, pend_y_q}) - dy;

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    to_d     = '0;
    err_d    = 1'b0;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    btn_d    = btn_q;
    case (state_q)
      WAIT_B0, APPLY: begin
        if (state_q == APPLY) begin
          btn_d = hdr_q[1:0];
          if (!hdr_q[4]) begin
            if (nx < 0)       pend_x_d = '0;
            else if (nx > XM) pend_x_d = XM[9:0];
            else              pend_x_d = nx[9:0];
          end
          if (!hdr_q[5]) begin
            if (ny < 0)       pend_y_d = '0;
            else if (ny > YM) pend_y_d = YM[8:0];
            else              pend_y_d = ny[8:0];
          end
        end
        // a byte arriving during APPLY is treated as a fresh first byte
        state_d = WAIT_B0;
        if (rx_valid) begin
          if (rx_data[3]) begin
            hdr_d   = {rx_data[7:4], rx_data[1:0]};
            state_d = WAIT_B1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_B1, WAIT_B2: begin
        if (rx_valid) begin
          if (state_q == WAIT_B1) begin
            b1_d    = rx_data;
            state_d = WAIT_B2;
          end else begin
            b2_d    = rx_data;
            state_d = APPLY;
          end
        end else if (to_q == TO_LAST) begin
          state_d = WAIT_B0;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = WAIT_B0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_B0;
      hdr_q     <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      to_q      <= '0;
      pend_x_q  <= 10'(X_INIT);
      pend_y_q  <= 9'(Y_INIT);
      mouse_x_q <= 10'(X_INIT);
      mouse_y_q <= 9'(Y_INIT);
      btn_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      to_q     <= to_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      btn_q    <= btn_d;
      err_q    <= err_d;
      if (frame_start) begin
        mouse_x_q <= pend_x_q;
        mouse_y_q <= pend_y_q;
      end
    end
  end

  assign mouse_x    = mouse_x_q;
  assign mouse_y    = mouse_y_q;
  assign btn_left   = btn_q[0];
  assign btn_right  = btn_q[1];
  assign packet_err = err_q;

endmodule
